// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - MD5 round constants, IV, engine state type and message index helper
package md5_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} md5_state_t;

    // Chaining layout is {d,c,b,a}, with a in the low word
    localparam logic [127:0] MD5_IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};

    localparam logic [31:0] MD5_K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] MD5_S [64] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    // Only round mod 16 matters for the index, so 4-bit arithmetic gives the mod 16 for free
    function automatic logic [3:0] md5_g(input logic [5:0] round);
        logic [3:0] r;
        r = round[3:0];
        unique case (round[5:4])
            2'd0:    return r;
            2'd1:    return 4'(r * 4'd5 + 4'd1);
            2'd2:    return 4'(r * 4'd3 + 4'd5);
            default: return 4'(r * 4'd7);
        endcase
    endfunction

endpackage

// File: rtl/md5_block_engine_if.sv
// rtl/md5_block_engine_if.sv - block/chain input and digest output handshake bundle
interface md5_block_engine_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic [127:0] chain_in;
    logic         use_iv;
    logic         dig_valid;
    logic         dig_ready;
    logic [127:0] digest;

    modport master (
        output blk_valid, blk_data, chain_in, use_iv, dig_ready,
        input  blk_ready, dig_valid, digest
    );

    modport slave (
        input  blk_valid, blk_data, chain_in, use_iv, dig_ready,
        output blk_ready, dig_valid, digest
    );
endinterface

// File: rtl/md5_round_core.sv
// rtl/md5_round_core.sv - one combinational MD5 round
module md5_round_core
    import md5_pkg::*;
(
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  logic [31:0]  c,
    input  logic [31:0]  d,
    input  logic [5:0]   round_num,
    input  logic [511:0] message,
    output logic [31:0]  a_next,
    output logic [31:0]  b_next,
    output logic [31:0]  c_next,
    output logic [31:0]  d_next
);

    logic [31:0] f;
    logic [31:0] m_word;
    logic [31:0] tmp;
    logic [63:0] dbl;
    logic [3:0]  g;
    logic [4:0]  s;

    always_comb begin
        f = '0;
        unique case (round_num[5:4])
            2'd0:    f = (b & c) | (~b & d);
            2'd1:    f = (d & b) | (~d & c);
            2'd2:    f = b ^ c ^ d;
            default: f = c ^ (b | ~d);
        endcase
        g      = md5_g(round_num);
        s      = MD5_S[round_num];
        m_word = message[{g, 5'd0} +: 32];
        tmp    = a + f + MD5_K[round_num] + m_word;
        // Rotate-left as the upper half of a doubled word shifted left
        dbl    = {tmp, tmp} << s;
    end

    assign a_next = d;
    assign b_next = b + dbl[63:32];
    assign c_next = b;
    assign d_next = c;

endmodule

// File: rtl/md5_block_engine.sv
// rtl/md5_block_engine.sv - sequential MD5 compression of one 512-bit block
module md5_block_engine
    import md5_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                abort,
    output logic                busy,
    md5_block_engine_if.slave   bus
);

    localparam logic [5:0] STEP = 6'(UNROLL);
    localparam logic [5:0] LAST = 6'(64 - UNROLL);

    md5_state_t   state, state_next;
    logic         accept;
    logic [5:0]   round_cnt;
    logic [511:0] msg_q;
    logic [127:0] chain_q;
    logic [127:0] digest_q;
    logic [127:0] sel_chain;
    logic [31:0]  a_q, b_q, c_q, d_q;

    assign sel_chain = bus.use_iv ? MD5_IV : bus.chain_in;

    for (genvar j = 0; j < UNROLL; j++) begin : stg
        logic [31:0] ia, ib, ic, id, oa, ob, oc, od;
        if (j == 0) begin : g_first
            assign {ia, ib, ic, id} = {a_q, b_q, c_q, d_q};
        end else begin : g_link
            assign {ia, ib, ic, id} = {stg[j-1].oa, stg[j-1].ob, stg[j-1].oc, stg[j-1].od};
        end
        md5_round_core u_core (
            .a         (ia),
            .b         (ib),
            .c         (ic),
            .d         (id),
            .round_num (round_cnt + 6'(j)),
            .message   (msg_q),
            .a_next    (oa),
            .b_next    (ob),
            .c_next    (oc),
            .d_next    (od)
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // abort overrides every transition, including a same-cycle accept or consume
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (bus.blk_valid) begin
                           state_next = ROUND;
                           accept     = 1'b1;
                       end
                ROUND: if (round_cnt == LAST) state_next = ADD;
                ADD:   state_next = DONE;
                DONE:  if (bus.dig_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_cnt <= '0;
            msg_q     <= '0;
            chain_q   <= '0;
            digest_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
        end else if (abort) begin
            round_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    msg_q                <= bus.blk_data;
                    chain_q              <= sel_chain;
                    {d_q, c_q, b_q, a_q} <= sel_chain;
                    round_cnt            <= '0;
                end
                ROUND: begin
                    a_q       <= stg[UNROLL-1].oa;
                    b_q       <= stg[UNROLL-1].ob;
                    c_q       <= stg[UNROLL-1].oc;
                    d_q       <= stg[UNROLL-1].od;
                    round_cnt <= round_cnt + STEP;
                end
                ADD: digest_q <= {chain_q[127:96] + d_q, chain_q[95:64] + c_q,
                                  chain_q[63:32]  + b_q, chain_q[31:0]  + a_q};
                default: ;
            endcase
        end
    end

    assign bus.blk_ready = (state == IDLE);
    assign bus.dig_valid = (state == DONE);
    assign bus.digest    = digest_q;
    assign busy          = (state == ROUND) || (state == ADD);

endmodule

// File: tb/tb_md5_block_engine.sv
// tb/tb_md5_block_engine.sv - directed bench for md5_block_engine
module tb_md5_block_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic abort4 = 1'b0;
    logic busy, busy4;

    md5_block_engine_if bus ();
    md5_block_engine_if bus4 ();

    md5_block_engine #(.UNROLL(1)) dut (
        .clk (clk), .rst_n (rst_n), .abort (abort), .busy (busy), .bus (bus.slave)
    );

    md5_block_engine #(.UNROLL(4)) dut4 (
        .clk (clk), .rst_n (rst_n), .abort (abort4), .busy (busy4), .bus (bus4.slave)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] DIG_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
    localparam logic [127:0] DIG_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
    localparam int ST [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0]  kt [64];
    logic [511:0] blk_empty, blk_abc;

    function automatic logic [127:0] md5_model(input logic [127:0] ch, input logic [511:0] m);
        logic [31:0] a, b, c, d, f, t;
        int g, s;
        a = ch[31:0]; b = ch[63:32]; c = ch[95:64]; d = ch[127:96];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i; end
                1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
            endcase
            s = ST[(i / 16) * 4 + i % 4];
            t = a + f + kt[i] + m[32 * g +: 32];
            t = (t << s) | (t >> (32 - s));
            a = d; d = c; c = b; b = b + t;
        end
        return {ch[127:96] + d, ch[95:64] + c, ch[63:32] + b, ch[31:0] + a};
    endfunction

    task automatic start_block(input logic [511:0] m, input logic [127:0] ch, input logic iv);
        @(negedge clk);
        n_cmp++;
        if (bus.blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ready: blk_ready=%b expected 1", bus.blk_ready);
        end
        bus.blk_data = m; bus.chain_in = ch; bus.use_iv = iv; bus.blk_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.blk_valid = 1'b0;
        bus.blk_data = {16{32'hdeadbeef}};
        bus.chain_in = {4{32'h5a5a5a5a}};
    endtask

    task automatic wait_dig(output int edges);
        edges = 0;
        while (!bus.dig_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.dig_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.dig_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp += 4;
        if (bus.blk_ready !== 1'b1) begin n_fail++; $display("FAIL reset_blk_ready: got %b expected 1", bus.blk_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (bus.dig_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dig_valid: got %b expected 0", bus.dig_valid); end
        if (bus.digest !== 128'h0) begin n_fail++; $display("FAIL reset_digest: got %h expected 0", bus.digest); end
    endtask

    task automatic test_empty();
        int edges;
        start_block(blk_empty, {4{32'hffffffff}}, 1'b1);
        n_cmp += 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy: got %b expected 1", busy); end
        if (bus.blk_ready !== 1'b0) begin n_fail++; $display("FAIL empty_blk_ready_busy: got %b expected 0", bus.blk_ready); end
        wait_dig(edges);
        n_cmp += 3;
        if (edges !== 65) begin n_fail++; $display("FAIL empty_latency: got %0d expected 65", edges); end
        if (bus.digest !== DIG_EMPTY) begin n_fail++; $display("FAIL empty_digest: got %h expected %h", bus.digest, DIG_EMPTY); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy_done: got %b expected 0", busy); end
        consume();
        n_cmp += 2;
        if (bus.dig_valid !== 1'b0) begin n_fail++; $display("FAIL empty_consume_valid: got %b expected 0", bus.dig_valid); end
        if (bus.blk_ready !== 1'b1) begin n_fail++; $display("FAIL empty_consume_ready: got %b expected 1", bus.blk_ready); end
    endtask

    task automatic test_abc();
        int edges;
        start_block(blk_abc, '0, 1'b1);
        wait_dig(edges);
        n_cmp += 2;
        if (edges !== 65) begin n_fail++; $display("FAIL abc_latency: got %0d expected 65", edges); end
        if (bus.digest !== DIG_ABC) begin n_fail++; $display("FAIL abc_digest: got %h expected %h", bus.digest, DIG_ABC); end
        consume();
    endtask

    task automatic test_backpressure();
        int edges;
        int bad = 0;
        start_block(blk_empty, '0, 1'b1);
        wait_dig(edges);
        @(negedge clk);
        bus.blk_data = blk_abc; bus.use_iv = 1'b1; bus.blk_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.dig_valid !== 1'b1 || bus.blk_ready !== 1'b0 || bus.digest !== DIG_EMPTY) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d of 20 cycles unstable, expected 0", bad); end
        consume();
        @(posedge clk);
        #1;
        bus.blk_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept: busy=%b expected 1", busy); end
        wait_dig(edges);
        n_cmp += 2;
        if (edges !== 65) begin n_fail++; $display("FAIL bp_second_latency: got %0d expected 65", edges); end
        if (bus.digest !== DIG_ABC) begin n_fail++; $display("FAIL bp_second_digest: got %h expected %h", bus.digest, DIG_ABC); end
        consume();
    endtask

    task automatic test_chaining();
        int edges;
        logic [127:0] exp;
        exp = md5_model(DIG_EMPTY, blk_empty);
        start_block(blk_empty, DIG_EMPTY, 1'b0);
        wait_dig(edges);
        n_cmp++;
        if (bus.digest !== exp) begin n_fail++; $display("FAIL chain_digest: got %h expected %h", bus.digest, exp); end
        consume();
    endtask

    task automatic test_abort();
        int edges;
        logic [127:0] prev;
        prev = bus.digest;
        start_block(blk_empty, '0, 1'b1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        bus.blk_data = blk_abc; bus.use_iv = 1'b1; bus.blk_valid = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        bus.blk_valid = 1'b0;
        n_cmp += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (bus.blk_ready !== 1'b1) begin n_fail++; $display("FAIL abort_not_accepted: blk_ready=%b expected 1", bus.blk_ready); end
        if (bus.dig_valid !== 1'b0) begin n_fail++; $display("FAIL abort_dig_valid: got %b expected 0", bus.dig_valid); end
        if (bus.digest !== prev) begin n_fail++; $display("FAIL abort_digest_kept: got %h expected %h", bus.digest, prev); end
        repeat (70) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.dig_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_result: dig_valid=%b expected 0", bus.dig_valid); end
        start_block(blk_abc, '0, 1'b1);
        wait_dig(edges);
        n_cmp++;
        if (bus.digest !== DIG_ABC) begin n_fail++; $display("FAIL abort_then_abc: got %h expected %h", bus.digest, DIG_ABC); end
        consume();
    endtask

    task automatic test_reset_mid();
        int edges;
        start_block(blk_abc, '0, 1'b1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (bus.blk_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_blk_ready: got %b expected 1", bus.blk_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        if (bus.dig_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_dig_valid: got %b expected 0", bus.dig_valid); end
        if (bus.digest !== 128'h0) begin n_fail++; $display("FAIL rstmid_digest: got %h expected 0", bus.digest); end
        @(negedge clk);
        rst_n = 1'b1;
        start_block(blk_empty, '0, 1'b1);
        wait_dig(edges);
        n_cmp += 2;
        if (edges !== 65) begin n_fail++; $display("FAIL rstmid_latency: got %0d expected 65", edges); end
        if (bus.digest !== DIG_EMPTY) begin n_fail++; $display("FAIL rstmid_digest_after: got %h expected %h", bus.digest, DIG_EMPTY); end
        consume();
    endtask

    task automatic test_unroll4();
        int edges = 0;
        @(negedge clk);
        bus4.blk_data = blk_abc; bus4.use_iv = 1'b1; bus4.blk_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.blk_valid = 1'b0;
        bus4.blk_data = '0;
        while (!bus4.dig_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_cmp += 2;
        if (edges !== 17) begin n_fail++; $display("FAIL u4_latency: got %0d expected 17", edges); end
        if (bus4.digest !== DIG_ABC) begin n_fail++; $display("FAIL u4_digest: got %h expected %h", bus4.digest, DIG_ABC); end
        @(negedge clk);
        bus4.dig_ready = 1'b1;
        @(posedge clk);
        #1;
        bus4.dig_ready = 1'b0;
    endtask

    initial begin
        real x;
        for (int i = 0; i < 64; i++) begin
            x = $sin(real'(i + 1));
            if (x < 0.0) x = -x;
            kt[i] = 32'(longint'($floor(x * 4294967296.0)));
        end
        blk_empty = '0;
        blk_empty[31:0] = 32'h00000080;
        blk_abc = '0;
        blk_abc[31:0] = 32'h80636261;
        blk_abc[14*32 +: 32] = 32'h00000018;

        bus.blk_valid = 1'b0; bus.blk_data = '0; bus.chain_in = '0; bus.use_iv = 1'b1; bus.dig_ready = 1'b0;
        bus4.blk_valid = 1'b0; bus4.blk_data = '0; bus4.chain_in = '0; bus4.use_iv = 1'b1; bus4.dig_ready = 1'b0;

        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_empty();
        test_abc();
        test_backpressure();
        test_chaining();
        test_abort();
        test_reset_mid();
        test_unroll4();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
